// File: rtl/xt_vc_sched_if.sv
// Request/response bus bundle for the virtual-channel scheduler.
interface xt_vc_sched_if #(
  parameter int unsigned VCN = 2,
  parameter int unsigned PW  = 32
) ();
  localparam int unsigned VW = $clog2(VCN);

  logic [VCN-1:0]    in_vld;
  logic [VCN*PW-1:0] in_pld;
  logic [VCN-1:0]    in_gnt;
  logic              req_vld;
  logic              req_gnt;
  logic [VW-1:0]     req_vc;
  logic [PW-1:0]     req_pld;
  logic              rsp_vld;
  logic              rsp_gnt;
  logic [VW-1:0]     rsp_vc;

  modport slave (
    input  in_vld, in_pld, req_gnt, rsp_vld, rsp_gnt, rsp_vc,
    output in_gnt, req_vld, req_vc, req_pld
  );

  modport master (
    output in_vld, in_pld, req_gnt, rsp_vld, rsp_gnt, rsp_vc,
    input  in_gnt, req_vld, req_vc, req_pld
  );
endinterface

// File: rtl/xt_vc_sched.sv
// Round-robin virtual-channel scheduler with per-VC outstanding-request credit.
module xt_vc_sched #(
  parameter int unsigned VCN = 2,
  parameter int unsigned BUF = 4,
  parameter int unsigned PW  = 32
) (
  input  logic         clk,
  input  logic         rstn,
  xt_vc_sched_if.slave bus,
  output logic         err,
  output logic         idle
);
  localparam int unsigned VW = $clog2(VCN);
  localparam int unsigned CW = $clog2(BUF + 1);
  localparam int unsigned XW = VW + 1;

  logic                   req_vld_q, req_vld_d;
  logic [VW-1:0]          req_vc_q,  req_vc_d;
  logic [PW-1:0]          req_pld_q, req_pld_d;
  logic [VW-1:0]          rr_ptr_q,  rr_ptr_d;
  logic [VCN-1:0][CW-1:0] cnt_q,     cnt_d;
  logic                   err_q,     err_d;
  logic                   idle_q,    idle_d;

  logic                   ld_en_c;
  logic [VCN-1:0]         elig_c;
  logic                   gnt_c;
  logic [VW-1:0]          sel_c;
  logic [XW-1:0]          idx_c;
  logic [VCN-1:0]         in_gnt_c;
  logic                   cpl_c;
  logic                   cpl_ok_c;
  logic                   inc_c;
  logic                   dec_c;

  // Eligibility and round-robin pick starting at rr_ptr; grant only when the holding register can load.
  always_comb begin
    ld_en_c  = rstn & (~req_vld_q | bus.req_gnt);
    elig_c   = '0;
    gnt_c    = 1'b0;
    sel_c    = '0;
    idx_c    = '0;
    in_gnt_c = '0;
    for (int unsigned v = 0; v < VCN; v++) begin
      elig_c[v] = bus.in_vld[v] & (cnt_q[v] < CW'(BUF));
    end
    for (int unsigned i = 0; i < VCN; i++) begin
      idx_c = XW'(rr_ptr_q) + XW'(i);
      if (idx_c >= XW'(VCN)) begin
        idx_c = idx_c - XW'(VCN);
      end
      if (!gnt_c && elig_c[idx_c[VW-1:0]]) begin
        gnt_c = 1'b1;
        sel_c = idx_c[VW-1:0];
      end
    end
    gnt_c = gnt_c & ld_en_c;
    if (gnt_c) begin
      in_gnt_c[sel_c] = 1'b1;
    end
  end

  // Next state: holding register, pointer, credit counters, sticky error, idle.
  always_comb begin
    req_vld_d = req_vld_q;
    req_vc_d  = req_vc_q;
    req_pld_d = req_pld_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    inc_c     = 1'b0;
    dec_c     = 1'b0;
    cpl_c     = bus.rsp_vld & bus.rsp_gnt;
    cpl_ok_c  = 1'b0;

    // A completion is only legal for an existing VC that has something outstanding.
    if (cpl_c && ({1'b0, bus.rsp_vc} < XW'(VCN))) begin
      cpl_ok_c = (cnt_q[bus.rsp_vc] != '0);
    end
    if (cpl_c && !cpl_ok_c) begin
      err_d = 1'b1;
    end

    if (gnt_c) begin
      req_vld_d = 1'b1;
      req_vc_d  = sel_c;
      req_pld_d = bus.in_pld[PW*int'(sel_c) +: PW];
      rr_ptr_d  = (sel_c == VW'(VCN - 1)) ? '0 : sel_c + VW'(1);
    end else if (bus.req_gnt) begin
      req_vld_d = 1'b0;
    end

    for (int unsigned v = 0; v < VCN; v++) begin
      inc_c = gnt_c & (sel_c == VW'(v));
      dec_c = cpl_ok_c & (bus.rsp_vc == VW'(v));
      if (inc_c && !dec_c) begin
        cnt_d[v] = cnt_q[v] + CW'(1);
      end else if (dec_c && !inc_c) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end
    end

    idle_d = ~req_vld_d & (cnt_d == '0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_vld_q <= 1'b0;
      req_vc_q  <= '0;
      req_pld_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      req_vld_q <= req_vld_d;
      req_vc_q  <= req_vc_d;
      req_pld_q <= req_pld_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.in_gnt  = in_gnt_c;
  assign bus.req_vld = req_vld_q;
  assign bus.req_vc  = req_vc_q;
  assign bus.req_pld = req_pld_q;
  assign err         = err_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_xt_vc_sched.sv
// Self-checking bench for xt_vc_sched: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_xt_vc_sched;
  localparam int unsigned VCN = 2;
  localparam int unsigned BUF = 4;
  localparam int unsigned PW  = 32;
  localparam int unsigned VW  = $clog2(VCN);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic err;
  logic idle;

  int checks = 0;
  int errors = 0;

  xt_vc_sched_if #(.VCN(VCN), .PW(PW)) bus ();

  xt_vc_sched #(.VCN(VCN), .BUF(BUF), .PW(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .err  (err),
    .idle (idle)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit            m_known = 1'b0;
  int            m_rr;
  int            m_cnt [VCN];
  bit            m_hv;
  int            m_hvc;
  logic [PW-1:0] m_hpld;
  bit            m_err;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which VC the rules say is granted right now, or -1.
  function automatic int m_sel();
    if (!rstn) return -1;
    if (m_known && m_hv && !bus.req_gnt) return -1;
    for (int i = 0; i < VCN; i++) begin
      int v;
      v = (m_rr + i) % VCN;
      if (bus.in_vld[v] && m_cnt[v] < BUF) return v;
    end
    return -1;
  endfunction

  task automatic compare_all(output int s);
    logic [VCN-1:0] eg;
    bit all_zero;
    s  = m_sel();
    eg = '0;
    if (s >= 0) eg[s] = 1'b1;
    chk("in_gnt", 64'(bus.in_gnt), 64'(eg));
    if (m_known) begin
      all_zero = 1'b1;
      for (int v = 0; v < VCN; v++) if (m_cnt[v] != 0) all_zero = 1'b0;
      chk("req_vld", 64'(bus.req_vld), 64'(m_hv));
      if (m_hv) begin
        chk("req_vc", 64'(bus.req_vc), 64'(m_hvc));
        chk("req_pld", 64'(bus.req_pld), 64'(m_hpld));
      end
      chk("err", 64'(err), 64'(m_err));
      chk("idle", 64'(idle), 64'(!m_hv && all_zero));
    end
  endtask

  task automatic m_update(bit r, logic [VCN*PW-1:0] pld, bit rg, bit cpl, int rvc, int s);
    int dvc;
    if (!r) begin
      m_known = 1'b1;
      m_hv    = 1'b0;
      m_rr    = 0;
      m_err   = 1'b0;
      for (int v = 0; v < VCN; v++) m_cnt[v] = 0;
      return;
    end
    if (!m_known) return;
    dvc = -1;
    if (cpl) begin
      if (rvc >= VCN || m_cnt[rvc] == 0) m_err = 1'b1;
      else dvc = rvc;
    end
    if (s >= 0) begin
      m_cnt[s]++;
      m_hv   = 1'b1;
      m_hvc  = s;
      m_hpld = pld[s*PW +: PW];
      m_rr   = (s + 1) % VCN;
    end else if (rg) begin
      m_hv = 1'b0;
    end
    if (dvc >= 0) m_cnt[dvc]--;
  endtask

  // One clock: compare at negedge+1, advance model across the posedge, return at next negedge.
  task automatic cycle();
    int s;
    bit r, rg, cpl;
    int rvc;
    logic [VCN*PW-1:0] pld;
    #1;
    compare_all(s);
    r   = rstn;
    rg  = bus.req_gnt;
    cpl = bus.rsp_vld & bus.rsp_gnt;
    rvc = int'(bus.rsp_vc);
    pld = bus.in_pld;
    @(posedge clk);
    m_update(r, pld, rg, cpl, rvc, s);
    @(negedge clk);
  endtask

  task automatic drive(logic [VCN-1:0] vld, bit rg, bit cpl, int rvc);
    bus.in_vld = vld;
    for (int v = 0; v < VCN; v++) bus.in_pld[v*PW +: PW] = $urandom();
    bus.req_gnt = rg;
    bus.rsp_vld = cpl;
    bus.rsp_gnt = cpl;
    bus.rsp_vc  = VW'(rvc);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive('0, 1'b0, 1'b0, 0);
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] p0;
    drive('0, 1'b0, 1'b0, 0);
    @(negedge clk);
    cycle();
    cycle();
    rstn = 1'b1;
    #1;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_req_vld", 64'(bus.req_vld), 64'd0);
    chk("rst_req_vc", 64'(bus.req_vc), 64'd0);
    chk("rst_req_pld", 64'(bus.req_pld), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Alternating grants with both VCs valid and the target always ready
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 1'b1, 1'b0, 0);
      #1;
      chk("rr_gnt", 64'(bus.in_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i > 0) chk("rr_req_vc", 64'(bus.req_vc), 64'((i - 1) % 2));
      cycle();
    end

    // Reset mid-operation drops the held request and all counts
    rstn = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 0);
    cycle();
    rstn = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 0);
    #1;
    chk("mid_rst_req_vld", 64'(bus.req_vld), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    chk("first_gnt_after_rst", 64'(bus.in_gnt), 64'd1);
    cycle();

    // Credit exhaustion on VC0, then one completion frees one slot
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1'b1, 1'b0, 0);
      #1;
      chk("credit_gnt", 64'(bus.in_gnt), (i < 4) ? 64'd1 : 64'd0);
      cycle();
    end
    drive(2'b01, 1'b1, 1'b1, 0);
    #1;
    chk("credit_full_gnt", 64'(bus.in_gnt), 64'd0);
    cycle();
    drive(2'b01, 1'b1, 1'b0, 0);
    #1;
    chk("credit_refill_gnt", 64'(bus.in_gnt), 64'd1);
    cycle();
    drive(2'b01, 1'b1, 1'b0, 0);
    #1;
    chk("credit_full_again", 64'(bus.in_gnt), 64'd0);
    cycle();

    // Backpressure holds the payload; release refills back-to-back
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 0);
    p0 = bus.in_pld[0 +: PW];
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 1'b0, 1'b0, 0);
      #1;
      chk("stall_gnt", 64'(bus.in_gnt), 64'd0);
      chk("stall_pld", 64'(bus.req_pld), 64'(p0));
      cycle();
    end
    drive(2'b11, 1'b1, 1'b0, 0);
    #1;
    chk("release_gnt", 64'(bus.in_gnt), 64'd2);
    cycle();
    drive(2'b00, 1'b1, 1'b0, 0);
    #1;
    chk("release_req_vc", 64'(bus.req_vc), 64'd1);
    cycle();

    // Simultaneous admission and completion on VC1 leaves the count at 2
    do_reset();
    drive(2'b10, 1'b1, 1'b0, 0); cycle();
    drive(2'b10, 1'b1, 1'b0, 0); cycle();
    drive(2'b10, 1'b1, 1'b1, 1);
    #1;
    chk("same_cycle_gnt", 64'(bus.in_gnt), 64'd2);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b1, 1'b0, 0);
      #1;
      chk("same_cycle_tail", 64'(bus.in_gnt), (i < 2) ? 64'd2 : 64'd0);
      cycle();
    end

    // Completion with nothing outstanding is a sticky error
    do_reset();
    drive(2'b00, 1'b1, 1'b1, 0);
    cycle();
    drive(2'b00, 1'b1, 1'b0, 0);
    #1;
    chk("err_set", 64'(err), 64'd1);
    chk("err_idle", 64'(idle), 64'd1);
    for (int i = 0; i < 3; i++) cycle();
    chk("err_sticky", 64'(err), 64'd1);
    do_reset();
    #1;
    chk("err_cleared", 64'(err), 64'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int rvc;
      bit cpl;
      rstn = ($urandom_range(0, 99) != 0);
      rvc  = $urandom_range(0, VCN - 1);
      cpl  = (m_cnt[rvc] > 0) && ($urandom_range(0, 1) == 1);
      drive(VCN'($urandom()), ($urandom_range(0, 9) < 7), cpl, rvc);
      if (!cpl && $urandom_range(0, 3) == 0) bus.rsp_vld = 1'b1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
